// File: rtl/flash_read_arbiter_if.sv
// Bundled requester, loader and flash-bus signals for flash_read_arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface flash_read_arbiter_if;
  logic        I_CPU_REQ;
  logic [23:0] I_CPU_ADDR;
  logic        O_CPU_ACK;
  logic [7:0]  O_CPU_DATA;
  logic        I_LDR_REQ;
  logic [22:0] I_LDR_ADDR;
  logic        O_LDR_ACK;
  logic [15:0] O_LDR_DATA;
  logic        O_BUSY;
  logic [15:0] I_FLASH_DATA;
  logic [23:0] O_FLASH_ADDR;
  logic        O_FLASH_CLK;
  logic        O_ADDR_VALID_L;
  logic        O_FLASH_CE_L;
  logic        O_FLASH_OE_L;
  logic        O_FLASH_WE_L;

  modport slave (
    input  I_CPU_REQ, I_CPU_ADDR, I_LDR_REQ, I_LDR_ADDR, I_FLASH_DATA,
    output O_CPU_ACK, O_CPU_DATA, O_LDR_ACK, O_LDR_DATA, O_BUSY,
           O_FLASH_ADDR, O_FLASH_CLK, O_ADDR_VALID_L, O_FLASH_CE_L,
           O_FLASH_OE_L, O_FLASH_WE_L
  );

  modport master (
    output I_CPU_REQ, I_CPU_ADDR, I_LDR_REQ, I_LDR_ADDR, I_FLASH_DATA,
    input  O_CPU_ACK, O_CPU_DATA, O_LDR_ACK, O_LDR_DATA, O_BUSY,
           O_FLASH_ADDR, O_FLASH_CLK, O_ADDR_VALID_L, O_FLASH_CE_L,
           O_FLASH_OE_L, O_FLASH_WE_L
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sequencing asynchronous flash reads for the CPU (bytes) and loader (words).
// Define FLASH_ARB_CACHE_EN to add a one-entry word cache that lets CPU hits skip the flash access.
module flash_read_arbiter #(
  parameter int P_WAIT_CYCLES = 4,
  parameter int P_CNT_W       = 4
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  flash_read_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_DONE} state_e;
  typedef enum logic {GNT_CPU, GNT_LDR} grant_e;

  state_e               state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  grant_e               owner_q, owner_d;
  logic [P_CNT_W-1:0]   cnt_q, cnt_d;
  logic [22:0]          addr_q, addr_d;
  logic                 lane_q, lane_d;
  logic [7:0]           cpu_data_q, cpu_data_d;
  logic [15:0]          ldr_data_q, ldr_data_d;
`ifdef FLASH_ARB_CACHE_EN
  logic [22:0]          tag_q, tag_d;
  logic                 tag_vld_q, tag_vld_d;
  logic [15:0]          word_q, word_d;
  logic                 cpu_hit;
`endif

  logic grant_cpu;
  logic grant_any;
  logic capture;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_LDR;
      owner_q      <= GNT_CPU;
      cnt_q        <= '0;
      addr_q       <= '0;
      lane_q       <= 1'b0;
      cpu_data_q   <= '0;
      ldr_data_q   <= '0;
`ifdef FLASH_ARB_CACHE_EN
      tag_q        <= '0;
      tag_vld_q    <= 1'b0;
      word_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      cpu_data_q   <= cpu_data_d;
      ldr_data_q   <= ldr_data_d;
`ifdef FLASH_ARB_CACHE_EN
      tag_q        <= tag_d;
      tag_vld_q    <= tag_vld_d;
      word_q       <= word_d;
`endif
    end
  end

  // A tie goes to whichever requester did not win the previous grant.
  always_comb begin
    grant_any = bus.I_CPU_REQ || bus.I_LDR_REQ;
    grant_cpu = bus.I_CPU_REQ && (!bus.I_LDR_REQ || (last_grant_q == GNT_LDR));
    capture   = (state_q == ST_WAIT) && (cnt_q == '0);
`ifdef FLASH_ARB_CACHE_EN
    cpu_hit   = tag_vld_q && (tag_q == bus.I_CPU_ADDR[23:1]);
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    cpu_data_d   = cpu_data_q;
    ldr_data_d   = ldr_data_q;
`ifdef FLASH_ARB_CACHE_EN
    tag_d        = tag_q;
    tag_vld_d    = tag_vld_q;
    word_d       = word_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          owner_d      = grant_cpu ? GNT_CPU : GNT_LDR;
          last_grant_d = owner_d;
          if (grant_cpu) begin
            lane_d = bus.I_CPU_ADDR[0];
`ifdef FLASH_ARB_CACHE_EN
            // Hit: serve the byte from the cached word and leave the flash address untouched.
            if (cpu_hit) begin
              state_d    = ST_DONE;
              cpu_data_d = bus.I_CPU_ADDR[0] ? word_q[15:8] : word_q[7:0];
            end else begin
              addr_d  = bus.I_CPU_ADDR[23:1];
              state_d = ST_SETUP;
            end
`else
            addr_d  = bus.I_CPU_ADDR[23:1];
            state_d = ST_SETUP;
`endif
          end else begin
            addr_d  = bus.I_LDR_ADDR;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = P_CNT_W'(P_WAIT_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) begin
          state_d = ST_DONE;
          if (owner_q == GNT_CPU) begin
            cpu_data_d = lane_q ? bus.I_FLASH_DATA[15:8] : bus.I_FLASH_DATA[7:0];
          end else begin
            ldr_data_d = bus.I_FLASH_DATA;
          end
`ifdef FLASH_ARB_CACHE_EN
          tag_d     = addr_q;
          tag_vld_d = 1'b1;
          word_d    = bus.I_FLASH_DATA;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.O_BUSY         = (state_q != ST_IDLE);
    bus.O_FLASH_CE_L   = !((state_q == ST_SETUP) || (state_q == ST_WAIT));
    bus.O_FLASH_OE_L   = bus.O_FLASH_CE_L;
    bus.O_ADDR_VALID_L = bus.O_FLASH_CE_L;
    bus.O_CPU_ACK      = (state_q == ST_DONE) && (owner_q == GNT_CPU);
    bus.O_LDR_ACK      = (state_q == ST_DONE) && (owner_q == GNT_LDR);
    bus.O_CPU_DATA     = cpu_data_q;
    bus.O_LDR_DATA     = ldr_data_q;
    bus.O_FLASH_ADDR   = {1'b0, addr_q};
    bus.O_FLASH_CLK    = 1'b1;
    bus.O_FLASH_WE_L   = 1'b1;
  end

endmodule
